// File: rtl/fir_seq_ctrl.sv
// Sequencing controller for fir_filter: coefficient load, one-at-a-time sample issue, result FIFO.
// Optional WAIT watchdog enabled by defining FIR_SEQ_CTRL_TIMEOUT_EN.
module fir_seq_ctrl #(
    parameter int FIR_ORDER = 4,
    parameter int OUT_DEPTH = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    input  logic [FIR_ORDER*16-1:0] cfg_coeff,
    output logic                    cfg_ready,
    input  logic                    s_valid,
    input  logic [15:0]             s_data,
    output logic                    s_ready,
    output logic                    m_valid,
    output logic [31:0]             m_data,
    input  logic                    m_ready,
    output logic                    fir_load,
    output logic [FIR_ORDER*16-1:0] fir_coeff,
    output logic                    fir_valid_in,
    output logic [15:0]             fir_signal_in,
    input  logic                    fir_valid_out,
    input  logic [31:0]             fir_signal_out,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int CB_W = FIR_ORDER * 16;
    localparam int AW   = $clog2(OUT_DEPTH);
    localparam int CW   = AW + 1;

    if ((OUT_DEPTH < 2) || ((OUT_DEPTH & (OUT_DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_bad_param
        $error("fir_seq_ctrl: OUT_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        ST_UNCFG   = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SETTLE1 = 3'd2,
        ST_SETTLE2 = 3'd3,
        ST_READY   = 3'd4,
        ST_ISSUE   = 3'd5,
        ST_WAIT    = 3'd6
    } state_t;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        logic [AW-1:0] r;
        if (p == AW'(OUT_DEPTH - 1)) begin
            r = {AW{1'b0}};
        end else begin
            r = p + {{(AW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_t            state_q;
    state_t            state_d;
    logic [CB_W-1:0]   coeff_q;
    logic [15:0]       sample_q;
    logic              cfg_ready_q;
    logic              s_ready_base_q;
    logic              fir_load_q;
    logic              fir_valid_in_q;
    logic              busy_q;

    logic [31:0]       mem_q [OUT_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              m_valid_q;

    logic              cfg_fire;
    logic              s_fire;
    logic              push;
    logic              pop;
    logic              timeout_hit;

    // A pending config masks sample acceptance in the same cycle
    assign s_ready   = s_ready_base_q & ~cfg_valid;
    assign cfg_ready = cfg_ready_q;
    assign cfg_fire  = cfg_valid & cfg_ready_q;
    assign s_fire    = s_valid & s_ready;
    assign push      = (state_q == ST_WAIT) & fir_valid_out;
    assign pop       = m_ready & m_valid_q;

    assign fir_load      = fir_load_q;
    assign fir_coeff     = coeff_q;
    assign fir_valid_in  = fir_valid_in_q;
    assign fir_signal_in = sample_q;
    assign busy          = busy_q;
    assign m_valid       = m_valid_q;
    assign m_data        = mem_q[rd_ptr_q];

    // Next-state decode for the sequencing FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNCFG: begin
                if (cfg_fire) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_UNCFG;
                end
            end
            ST_LOAD:    state_d = ST_SETTLE1;
            ST_SETTLE1: state_d = ST_SETTLE2;
            ST_SETTLE2: state_d = ST_READY;
            ST_READY: begin
                if (cfg_fire) begin
                    state_d = ST_LOAD;
                end else if (s_fire) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_ISSUE:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (fir_valid_out || timeout_hit) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default:    state_d = ST_UNCFG;
        endcase
    end

    // FIFO occupancy update
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // FSM state, latched operands and registered handshake/strobe outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_UNCFG;
            coeff_q        <= {CB_W{1'b0}};
            sample_q       <= 16'h0000;
            cfg_ready_q    <= 1'b1;
            s_ready_base_q <= 1'b0;
            fir_load_q     <= 1'b0;
            fir_valid_in_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cfg_ready_q    <= (state_d == ST_UNCFG) || (state_d == ST_READY);
            s_ready_base_q <= (state_d == ST_READY) && (count_d < CW'(OUT_DEPTH));
            fir_load_q     <= (state_d == ST_LOAD);
            fir_valid_in_q <= (state_d == ST_ISSUE);
            busy_q         <= (state_d == ST_LOAD)    || (state_d == ST_SETTLE1) ||
                              (state_d == ST_SETTLE2) || (state_d == ST_ISSUE)   ||
                              (state_d == ST_WAIT);
            if (cfg_fire) begin
                coeff_q <= cfg_coeff;
            end
            if (s_fire) begin
                sample_q <= s_data;
            end
        end
    end

    // FIFO pointers, count and head-valid flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {CW{1'b0}};
            m_valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q   <= count_d;
            m_valid_q <= (count_d != {CW{1'b0}});
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= fir_signal_out;
        end
    end

`ifdef FIR_SEQ_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt_q;
    logic          err_q;

    assign timeout_hit = (state_q == ST_WAIT) && !fir_valid_out &&
                         (wait_cnt_q == TW'(TIMEOUT - 1));
    assign err_timeout = err_q;

    // WAIT-cycle counter, zero on every WAIT entry; sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_q <= {TW{1'b0}};
            err_q      <= 1'b0;
        end else begin
            if (state_q != ST_WAIT) begin
                wait_cnt_q <= {TW{1'b0}};
            end else begin
                wait_cnt_q <= wait_cnt_q + {{(TW-1){1'b0}}, 1'b1};
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Randomized self-checking bench for fir_seq_ctrl with a behavioural fir_filter stand-in.
module tb_fir_seq_ctrl;

    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [63:0]   cfg_coeff = 64'h0;
    logic          cfg_ready;
    logic          s_valid = 1'b0;
    logic [15:0]   s_data = 16'h0;
    logic          s_ready;
    logic          m_valid;
    logic [31:0]   m_data;
    logic          m_ready = 1'b0;
    logic          fir_load;
    logic [63:0]   fir_coeff;
    logic          fir_valid_in;
    logic [15:0]   fir_signal_in;
    logic          fir_valid_out = 1'b0;
    logic [31:0]   fir_signal_out = 32'h0;
    logic          busy;
    logic          err_timeout;

    fir_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_coeff(cfg_coeff), .cfg_ready(cfg_ready),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .fir_load(fir_load), .fir_coeff(fir_coeff),
        .fir_valid_in(fir_valid_in), .fir_signal_in(fir_signal_in),
        .fir_valid_out(fir_valid_out), .fir_signal_out(fir_signal_out),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] fir_y(input logic [63:0] c, input logic [15:0] h [NT]);
        logic [31:0] acc;
        acc = 32'h0;
        for (int k = 0; k < NT; k++) acc += 32'(c[16*k +: 16]) * 32'(h[k]);
        return acc;
    endfunction

    // Behavioural filter: fixed or random latency, optional output suppression
    int          fixed_lat = 3;
    bit          suppress = 1'b0;
    int          f_cnt = 0;
    logic [31:0] f_res = 32'h0;
    logic [63:0] f_coeff = 64'h0;
    logic [15:0] f_hist [NT] = '{default: 16'h0};

    always @(negedge clk) begin
        logic [15:0] h [NT];
        if (f_cnt == 1) begin
            fir_valid_out  <= !suppress;
            fir_signal_out <= f_res;
        end else begin
            fir_valid_out  <= 1'b0;
            fir_signal_out <= $urandom();
        end
        if (f_cnt > 0) f_cnt <= f_cnt - 1;
        if (fir_load) begin
            f_coeff <= fir_coeff;
            f_hist  <= '{default: 16'h0};
        end
        if (fir_valid_in) begin
            h[0] = fir_signal_in;
            for (int k = 1; k < NT; k++) h[k] = f_hist[k-1];
            f_hist <= h;
            f_res  <= fir_y(f_coeff, h);
            f_cnt  <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
        end
    end

    // Reference model: expected output stream from accepted samples and coefficients
    logic [63:0] ref_coeff = 64'h0;
    logic [15:0] ref_hist [NT] = '{default: 16'h0};
    logic [31:0] exp_q [$];
    logic [31:0] pop_log [$];
    bit          acc_flag;
    bit          cfg_flag;
    bit          rand_mready = 1'b0;

    task automatic step();
        #1;
        acc_flag = 1'b0;
        cfg_flag = 1'b0;
        if (rst) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("pop_vs_model_depth", 64'(exp_q.size()), 64'd1);
                else chk("m_data", 64'(m_data), 64'(exp_q.pop_front()));
                pop_log.push_back(m_data);
            end
            if (s_valid && s_ready) begin
                for (int k = NT - 1; k > 0; k--) ref_hist[k] = ref_hist[k-1];
                ref_hist[0] = s_data;
                exp_q.push_back(fir_y(ref_coeff, ref_hist));
                acc_flag = 1'b1;
            end
            if (cfg_valid && cfg_ready) begin
                ref_coeff = cfg_coeff;
                ref_hist  = '{default: 16'h0};
                cfg_flag  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (rand_mready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_sample(input logic [15:0] x);
        s_valid = 1'b1;
        s_data  = x;
        for (int i = 0; i < 200; i++) begin
            step();
            if (acc_flag) break;
        end
        chk("s_accept", 64'(acc_flag), 64'd1);
        s_valid = 1'b0;
    endtask

    task automatic send_cfg(input logic [63:0] c);
        cfg_valid = 1'b1;
        cfg_coeff = c;
        for (int i = 0; i < 200; i++) begin
            step();
            if (cfg_flag) break;
        end
        chk("cfg_accept", 64'(cfg_flag), 64'd1);
        cfg_valid = 1'b0;
    endtask

    task automatic drain();
        rand_mready = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [15:0] samp [6];
        int idx;

        // Reset and pre-configuration behaviour
        s_valid = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_fir_load", 64'(fir_load), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("uncfg_s_ready", 64'(s_ready), 64'd0);
        end
        s_valid = 1'b0;

        // Config timing and directed stream
        send_cfg({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        chk("load_pulse", 64'(fir_load), 64'd1);
        chk("load_coeff", fir_coeff, 64'h0004_0003_0002_0001);
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_cfg_ready", 64'(cfg_ready), 64'd0);
        step();
        chk("settle1_load", 64'(fir_load), 64'd0);
        chk("settle1_s_ready", 64'(s_ready), 64'd0);
        step();
        chk("settle2_s_ready", 64'(s_ready), 64'd0);
        step();
        chk("ready_s_ready", 64'(s_ready), 64'd1);
        m_ready = 1'b1;
        pop_log.delete();
        send_sample(16'h0001);
        chk("issue_valid_in", 64'(fir_valid_in), 64'd1);
        chk("issue_signal_in", 64'(fir_signal_in), 64'h1);
        step();
        chk("wait_valid_in", 64'(fir_valid_in), 64'd0);
        chk("wait_busy", 64'(busy), 64'd1);
        send_sample(16'h0002);
        send_sample(16'h0003);
        drain();
        chk("stream_count", 64'(pop_log.size()), 64'd3);
        if (pop_log.size() == 3) begin
            chk("stream_y0", 64'(pop_log[0]), 64'h1);
            chk("stream_y1", 64'(pop_log[1]), 64'h4);
            chk("stream_y2", 64'(pop_log[2]), 64'hA);
        end

        // Backpressure: FIFO fills at 4, rest accepted after draining
        fixed_lat = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) samp[i] = 16'($urandom());
        idx = 0;
        for (int i = 0; i < 60; i++) begin
            s_valid = 1'b1;
            s_data  = samp[idx];
            step();
            if (acc_flag) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'd4);
        #1;
        chk("bp_s_ready", 64'(s_ready), 64'd0);
        chk("bp_m_valid", 64'(m_valid), 64'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 200 && idx < 6; i++) begin
            s_valid = 1'b1;
            s_data  = samp[idx];
            step();
            if (acc_flag) idx++;
        end
        s_valid = 1'b0;
        chk("bp_all_accepted", 64'(idx), 64'd6);
        drain();

        // Config wins over a simultaneous sample
        cfg_valid = 1'b1;
        cfg_coeff = {$urandom(), $urandom()};
        s_valid   = 1'b1;
        s_data    = 16'($urandom());
        #1;
        chk("sim_s_ready", 64'(s_ready), 64'd0);
        chk("sim_cfg_ready", 64'(cfg_ready), 64'd1);
        step();
        chk("sim_cfg_taken", 64'(cfg_flag), 64'd1);
        chk("sim_s_not_taken", 64'(acc_flag), 64'd0);
        cfg_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("sim_s_ready_hold", 64'(s_ready), 64'd0);
            step();
        end
        chk("sim_s_ready_back", 64'(s_ready), 64'd1);
        step();
        chk("sim_s_taken", 64'(acc_flag), 64'd1);
        s_valid = 1'b0;
        drain();

        // Push and pop in the same cycle with one entry
        fixed_lat = 3;
        m_ready = 1'b0;
        send_sample(16'($urandom()));
        for (int i = 0; i < 20 && !m_valid; i++) step();
        send_sample(16'($urandom()));
        repeat (3) step();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        #1;
        chk("pp_m_valid", 64'(m_valid), 64'd1);
        if (exp_q.size() > 0) chk("pp_new_head", 64'(m_data), 64'(exp_q[0]));
        step();
        chk("pp_head_stable", 64'(m_valid), 64'd1);
        m_ready = 1'b1;
        step();
        chk("pp_count_one", 64'(m_valid), 64'd0);
        drain();

`ifdef FIR_SEQ_CTRL_TIMEOUT_EN
        // Watchdog: suppressed filter output
        suppress = 1'b1;
        send_sample(16'($urandom()));
        void'(exp_q.pop_back());
        repeat (15) step();
        chk("wd_err_early", 64'(err_timeout), 64'd0);
        chk("wd_busy", 64'(busy), 64'd1);
        step();
        chk("wd_err_set", 64'(err_timeout), 64'd1);
        chk("wd_s_ready", 64'(s_ready), 64'd1);
        chk("wd_no_push", 64'(m_valid), 64'd0);
        repeat (6) step();
        suppress = 1'b0;
        chk("wd_err_sticky", 64'(err_timeout), 64'd1);
`else
        chk("err_tied_low", 64'(err_timeout), 64'd0);
`endif

        // Reset during WAIT with two FIFO entries
        m_ready = 1'b0;
        send_sample(16'($urandom()));
        send_sample(16'($urandom()));
        send_sample(16'($urandom()));
        step();
        chk("mid_m_valid", 64'(m_valid), 64'd1);
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_q.delete();
        chk("mid_fifo_empty", 64'(m_valid), 64'd0);
        chk("mid_busy_clr", 64'(busy), 64'd0);
        chk("mid_cfg_ready", 64'(cfg_ready), 64'd1);
        chk("mid_s_ready", 64'(s_ready), 64'd0);
        chk("mid_coeff_clr", fir_coeff, 64'h0);
        chk("mid_signal_in", 64'(fir_signal_in), 64'h0);
        chk("mid_err_clr", 64'(err_timeout), 64'd0);
        repeat (3) step();
        chk("mid_late_ignored", 64'(m_valid), 64'd0);

        // Randomized traffic with random latency and consumer stalls
        fixed_lat = 0;
        for (int n = 0; n < 40; n++) begin
            if (n % 10 == 0) begin
                rand_mready = 1'b0;
                drain();
                send_cfg({$urandom(), $urandom()});
                rand_mready = 1'b1;
            end
            send_sample(16'($urandom()));
            repeat ($urandom_range(0, 2)) step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencing controller in front of `fir_filter`. Accepts a coefficient set and a stream of 16-bit samples over valid/ready handshakes, drives the filter's `load` / `valid_in` strobes with the required spacing, and collects each 32-bit result into a small output FIFO with a valid/ready handshake toward the consumer. One sample is in flight in the filter at a time.

## Interface
- `FIR_ORDER`, 4: number of taps; coefficient bus width is `FIR_ORDER*16`.
- `OUT_DEPTH`, 4: output FIFO entries; must be a power of 2 and at least 2.
- `TIMEOUT`, 15: WAIT-state cycle limit; used only with the watchdog compiled in.

Ports:
- `clk` input 1: clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `cfg_valid` input 1: coefficient set offered.
- `cfg_coeff` input FIR_ORDER*16: tap k in bits [16k+15:16k].
- `cfg_ready` output 1: coefficient set can be accepted.
- `s_valid` input 1: input sample offered.
- `s_data` input 16: input sample.
- `s_ready` output 1: sample can be accepted.
- `m_valid` output 1: FIFO non-empty.
- `m_data` output 32: FIFO head (first-word fall-through).
- `m_ready` input 1: consumer pops the head.
- `fir_load` output 1: to filter `load`.
- `fir_coeff` output FIR_ORDER*16: to filter `coeff_in`.
- `fir_valid_in` output 1: to filter `valid_in`.
- `fir_signal_in` output 16: to filter `signal_in`.
- `fir_valid_out` input 1: from filter `valid_out`.
- `fir_signal_out` input 32: from filter `signal_out`.
- `busy` output 1: high in LOAD, SETTLE, ISSUE and WAIT.
- `err_timeout` output 1: sticky watchdog flag.

## Operation
**Reset (`rst`=0 at a clock edge)**
- State goes to UNCFG.
- FIFO is emptied; the coefficient register is cleared to 0.
- `err_timeout`, `fir_load`, `fir_valid_in`, `fir_signal_in`, `m_valid` and `busy` are all 0.
- `cfg_ready`=1, `s_ready`=0.
- Reset mid-operation abandons any in-flight sample; a late `fir_valid_out` is ignored.

**States**
- UNCFG: `cfg_ready`=1, `s_ready`=0. `cfg_valid` moves to LOAD and latches `cfg_coeff`.
- LOAD: one cycle with `fir_load`=1. `fir_coeff` holds the latched set in all states.
- SETTLE: two cycles, then READY.
- READY:
  - `cfg_ready`=1.
  - `s_ready` = (FIFO count < OUT_DEPTH) && !`cfg_valid`. Configuration has priority over samples in the same cycle.
  - A config handshake moves to LOAD.
  - A sample handshake latches `s_data` and moves to ISSUE.
- ISSUE: one cycle with `fir_valid_in`=1 and `fir_signal_in` = the latched sample, then WAIT.
- WAIT: on `fir_valid_out`=1, push `fir_signal_out` into the FIFO and move to READY.
- `cfg_ready`=0 and `s_ready`=0 in LOAD, SETTLE, ISSUE and WAIT.
- `fir_valid_out` outside WAIT is ignored.

**FIFO**
- Circular buffer with read and write pointers and a count of width log2(OUT_DEPTH)+1.
- Pointers wrap at OUT_DEPTH.
- Push and pop in the same cycle leave the count unchanged; a pop of a single-entry FIFO with a simultaneous push yields the new word as head.
- Overflow cannot occur: acceptance requires a free slot and at most one sample is in flight.
- Pop when empty has no effect.

**Arithmetic**
- No arithmetic on data; results pass through unmodified at 32 bits.

## Timing
- Config handshake at cycle C: `fir_load`=1 at C+1, SETTLE at C+2 and C+3, READY at C+4 (`s_ready` can be 1 at C+4).
- Sample handshake at cycle T: `fir_valid_in`=1 at T+1 only; WAIT from T+2.
- `fir_valid_out` sampled at cycle U≥T+2: `m_valid`=1 at U+1 if the FIFO was empty; READY at U+1.
- Peak rate is one sample per (filter latency + 2) cycles.
- `m_data` is stable while `m_valid`=1 and `m_ready`=0.

## Configuration
- `FIR_SEQ_CTRL_TIMEOUT_EN` defined:
  - A WAIT counter runs, cleared on WAIT entry.
  - If TIMEOUT cycles elapse without `fir_valid_out`, `err_timeout` is set and stays set until reset.
  - Nothing is pushed, and the state returns to READY.
- Not defined: no counter; WAIT holds indefinitely; `err_timeout` is tied to 0.

## Test plan
- **Reset values:** reset 3 cycles, then release -> `cfg_ready`=1, `s_ready`=0, `m_valid`=0, `busy`=0; `s_valid`=1 is never accepted before configuration.
- **Config then stream:** config {0x0004,0x0003,0x0002,0x0001} at C -> `fir_load` pulse at C+1 with that value, `s_ready`=1 at C+4. Stream samples 0x0001, 0x0002, 0x0003 against a behavioural filter model with latency 3 -> `m_data` 0x00000001, 0x00000004, 0x0000000A in order.
- **Backpressure:** `m_ready`=0, OUT_DEPTH=4, 6 samples offered -> exactly 4 accepted; `s_ready` held 0. Raising `m_ready` drains 4 words in order, then the remaining 2 are accepted.
- **Simultaneous events:** `cfg_valid` and `s_valid` both high in READY -> config taken, sample not accepted until after SETTLE. Push and pop in the same cycle at count=1 -> count stays 1 with the new head.
- **Watchdog:** with `FIR_SEQ_CTRL_TIMEOUT_EN` and the model's `fir_valid_out` suppressed -> `err_timeout`=1 exactly 15 cycles after WAIT entry, no FIFO push, `s_ready` returns to 1.
- **Reset mid-operation:** reset asserted in WAIT with 2 FIFO entries -> FIFO empty, state UNCFG, `fir_coeff`=0. The model's late `fir_valid_out` is not pushed.
